// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory port for the OTTER fetch stage.
//
//   Signals
//     IMEM_REQ     fetch -> mem   request valid
//     IMEM_ADDR    fetch -> mem   word address of the request (= PC)
//     IMEM_GNT     mem -> fetch   request accepted this cycle
//     IMEM_RVALID  mem -> fetch   response valid (one per grant, in order)
//     IMEM_RDATA   mem -> fetch   response instruction
//
//   Handshake: a request transfers on a posedge where IMEM_REQ && IMEM_GNT.
//   While IMEM_REQ=1 and no grant, IMEM_ADDR holds steady. The requester may
//   drop IMEM_REQ without a grant only when a branch redirect or the credit
//   limit forces it. Each grant is answered by exactly one IMEM_RVALID pulse,
//   at least one cycle later, in grant order; the response side has no
//   back-pressure.
//
//   Modports
//     master  fetch stage side
//     slave   instruction memory side
// ---------------------------------------------------------------------------
interface fetch_stage_if;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_GNT;
   logic        IMEM_RVALID;
   logic [31:0] IMEM_RDATA;

   modport master (
      output IMEM_REQ,
      output IMEM_ADDR,
      input  IMEM_GNT,
      input  IMEM_RVALID,
      input  IMEM_RDATA
   );

   modport slave (
      input  IMEM_REQ,
      input  IMEM_ADDR,
      output IMEM_GNT,
      output IMEM_RVALID,
      output IMEM_RDATA
   );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the pipelined OTTER. Holds the PC, issues
//   requests to instruction memory, remembers the address of every request
//   in flight, buffers returned instructions and drives the IF/ID register
//   consumed by decode. Stalls from the hazard unit freeze IF/ID; branch
//   redirects reload the PC, flush the buffer and discard responses that are
//   still in flight for the old path.
//
//   Parameters
//     RESET_PC   PC fetched first after reset
//     BUF_DEPTH  credit limit: requests in flight + buffered instructions
//                (power of 2, >= 2)
//     NOP_INSTR  bubble instruction placed in IF/ID
//
//   Ports
//     REG_CLOCK    clock, all state on posedge
//     REG_RESET_N  asynchronous active-low reset
//     IF_STALL     hold IF/ID and the buffer head
//     BR_TAKEN     redirect fetch to BR_TARGET this cycle (wins over stall)
//     BR_TARGET    redirect target, low two bits ignored
//     imem         instruction-memory port (master side)
//     FR_MEM       IF/ID instruction
//     FR_PC        IF/ID PC of FR_MEM
//     FR_PC_4      IF/ID FR_PC + 4
//     FR_VALID     IF/ID holds a real instruction (0 = bubble)
//     DBG_STATE    fetch FSM state: 0 = RUN, 1 = DRAIN
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic          REG_CLOCK,
   input  logic          REG_RESET_N,
   input  logic          IF_STALL,
   input  logic          BR_TAKEN,
   input  logic [31:0]   BR_TARGET,
   fetch_stage_if.master imem,
   output logic [31:0]   FR_MEM,
   output logic [31:0]   FR_PC,
   output logic [31:0]   FR_PC_4,
   output logic          FR_VALID,
   output logic          DBG_STATE
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   typedef enum logic {
      S_RUN   = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   state_t        state;
   logic [31:0]   pc;

   // Address FIFO: PC of every granted request that has not yet returned.
   logic [31:0]   af_mem [BUF_DEPTH];
   logic [PW-1:0] af_rd;
   logic [PW-1:0] af_wr;

   // Instruction buffer: returned {pc, instruction} pairs awaiting IF/ID.
   logic [31:0]   ib_pc    [BUF_DEPTH];
   logic [31:0]   ib_instr [BUF_DEPTH];
   logic [PW-1:0] ib_rd;
   logic [PW-1:0] ib_wr;

   logic [CW-1:0] out_cnt;    // requests granted, response still to come
   logic [CW-1:0] buf_cnt;    // entries in the instruction buffer
   logic [CW-1:0] drop_cnt;   // responses still to be thrown away
   logic [CW-1:0] drop_next;  // drop count loaded by a redirect

   logic          dropping;
   logic          credit_ok;
   logic          req;
   logic          grant;
   logic          rsp_keep;
   logic          rsp_drop;
   logic          bypass;
   logic          pop;
   logic          push;
   logic [31:0]   rsp_pc;
   logic [31:0]   head_pc;
   logic [31:0]   head_instr;

   // Low target bits are forced to zero; they are deliberately not used.
   logic          unused_target_lsbs;
   assign unused_target_lsbs = ^BR_TARGET[1:0];

   // ------------------------------------------------------------------------
   // Request / response decode
   // ------------------------------------------------------------------------
   always_comb begin
      dropping   = (drop_cnt != '0);
      // Registered counts only: a pop in this cycle frees its credit next
      // cycle. out+buf never exceeds BUF_DEPTH, so CW bits cannot overflow.
      credit_ok  = ((out_cnt + buf_cnt) < DEPTH_C);
      // Reset is folded in so no request leaves while the stage is held.
      req        = REG_RESET_N && credit_ok && !BR_TAKEN && !dropping;
      grant      = req && imem.IMEM_GNT;
      rsp_keep   = imem.IMEM_RVALID && !dropping;
      rsp_drop   = imem.IMEM_RVALID && dropping;
      rsp_pc     = af_mem[af_rd];
      head_pc    = ib_pc[ib_rd];
      head_instr = ib_instr[ib_rd];
      pop        = !BR_TAKEN && !IF_STALL && (buf_cnt != '0);
      // A fresh response skips the buffer only when nothing older waits.
      bypass     = rsp_keep && !BR_TAKEN && !IF_STALL && (buf_cnt == '0);
      push       = rsp_keep && !BR_TAKEN && !bypass;
      // Everything still in flight on a redirect becomes garbage, except a
      // response arriving this very cycle, which is discarded right now.
      drop_next  = drop_cnt + out_cnt - (imem.IMEM_RVALID ? ONE_C : '0);
   end

   assign imem.IMEM_REQ  = req;
   assign imem.IMEM_ADDR = pc;
   assign DBG_STATE      = (state == S_DRAIN);

   // ------------------------------------------------------------------------
   // Storage arrays (contents are don't-care while their count is zero)
   // ------------------------------------------------------------------------
   always_ff @(posedge REG_CLOCK) begin
      if (grant) begin
         af_mem[af_wr] <= pc;
      end
      if (push) begin
         ib_pc[ib_wr]    <= rsp_pc;
         ib_instr[ib_wr] <= imem.IMEM_RDATA;
      end
   end

   // ------------------------------------------------------------------------
   // FSM, PC, counters, pointers and IF/ID register
   // ------------------------------------------------------------------------
   always_ff @(posedge REG_CLOCK or negedge REG_RESET_N) begin
      if (!REG_RESET_N) begin
         state    <= S_RUN;
         pc       <= RESET_PC;
         af_rd    <= '0;
         af_wr    <= '0;
         ib_rd    <= '0;
         ib_wr    <= '0;
         out_cnt  <= '0;
         buf_cnt  <= '0;
         drop_cnt <= '0;
         FR_MEM   <= NOP_INSTR;
         FR_PC    <= 32'h0000_0000;
         FR_PC_4  <= 32'h0000_0000;
         FR_VALID <= 1'b0;
      end else if (BR_TAKEN) begin
         // Redirect: no grant is possible this cycle because REQ is low.
         pc       <= {BR_TARGET[31:2], 2'b00};
         af_rd    <= '0;
         af_wr    <= '0;
         ib_rd    <= '0;
         ib_wr    <= '0;
         out_cnt  <= '0;
         buf_cnt  <= '0;
         drop_cnt <= drop_next;
         state    <= (drop_next != '0) ? S_DRAIN : S_RUN;
         FR_MEM   <= NOP_INSTR;
         FR_VALID <= 1'b0;
      end else begin
         // FSM: DRAIN ends with the last discarded response.
         if (state == S_DRAIN && rsp_drop && drop_cnt == ONE_C) begin
            state <= S_RUN;
         end

         if (rsp_drop) begin
            drop_cnt <= drop_cnt - ONE_C;
         end

         if (grant) begin
            pc    <= pc + 32'd4;
            af_wr <= af_wr + 1'b1;
         end
         if (rsp_keep) begin
            af_rd <= af_rd + 1'b1;
         end

         case ({grant, rsp_keep})
            2'b10:   out_cnt <= out_cnt + ONE_C;
            2'b01:   out_cnt <= out_cnt - ONE_C;
            default: out_cnt <= out_cnt;
         endcase

         if (push) begin
            ib_wr <= ib_wr + 1'b1;
         end
         if (pop) begin
            ib_rd <= ib_rd + 1'b1;
         end
         case ({push, pop})
            2'b10:   buf_cnt <= buf_cnt + ONE_C;
            2'b01:   buf_cnt <= buf_cnt - ONE_C;
            default: buf_cnt <= buf_cnt;
         endcase

         // IF/ID: stall holds everything; otherwise oldest instruction first.
         if (!IF_STALL) begin
            if (pop) begin
               FR_MEM   <= head_instr;
               FR_PC    <= head_pc;
               FR_PC_4  <= head_pc + 32'd4;
               FR_VALID <= 1'b1;
            end else if (bypass) begin
               FR_MEM   <= imem.IMEM_RDATA;
               FR_PC    <= rsp_pc;
               FR_PC_4  <= rsp_pc + 32'd4;
               FR_VALID <= 1'b1;
            end else begin
               FR_MEM   <= NOP_INSTR;
               FR_VALID <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. The main instance talks to a memory model
//   with programmable latency that returns addr ^ 32'hA5A5_0000. A second
//   instance with RESET_PC = 32'hFFFF_FFF8 runs free against a 1-cycle memory
//   to show PC wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] MASK = 32'hA5A5_0000;

   // ---------------- clock / reset ----------------
   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        br;
   logic [31:0] tgt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   fetch_stage_if bus ();
   fetch_stage_if bus2 ();

   logic [31:0] fr_mem, fr_pc, fr_pc_4;
   logic        fr_valid, dbg_state;
   logic [31:0] fr_mem2, fr_pc2, fr_pc_42;
   logic        fr_valid2, dbg_state2;

   fetch_stage u_dut (
      .REG_CLOCK   (clk),
      .REG_RESET_N (rst_n),
      .IF_STALL    (stall),
      .BR_TAKEN    (br),
      .BR_TARGET   (tgt),
      .imem        (bus),
      .FR_MEM      (fr_mem),
      .FR_PC       (fr_pc),
      .FR_PC_4     (fr_pc_4),
      .FR_VALID    (fr_valid),
      .DBG_STATE   (dbg_state)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
      .REG_CLOCK   (clk),
      .REG_RESET_N (rst_n),
      .IF_STALL    (1'b0),
      .BR_TAKEN    (1'b0),
      .BR_TARGET   (32'h0000_0000),
      .imem        (bus2),
      .FR_MEM      (fr_mem2),
      .FR_PC       (fr_pc2),
      .FR_PC_4     (fr_pc_42),
      .FR_VALID    (fr_valid2),
      .DBG_STATE   (dbg_state2)
   );

   // ---------------- memory models ----------------
   logic [31:0] pend_a[$];
   int          pend_due[$];
   int          cyc;
   int          lat;
   logic        g2;
   logic [31:0] a2;

   initial cyc = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         pend_a.delete();
         pend_due.delete();
         g2 = 1'b0;
         a2 = 32'h0;
      end else begin
         if (bus.IMEM_RVALID === 1'b1) begin
            void'(pend_a.pop_front());
            void'(pend_due.pop_front());
         end
         if (bus.IMEM_REQ && bus.IMEM_GNT) begin
            pend_a.push_back(bus.IMEM_ADDR);
            pend_due.push_back(cyc + lat);
         end
         g2 = bus2.IMEM_REQ && bus2.IMEM_GNT;
         a2 = bus2.IMEM_ADDR;
      end
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      if (pend_a.size() > 0 && pend_due[0] <= cyc) begin
         bus.IMEM_RVALID = 1'b1;
         bus.IMEM_RDATA  = pend_a[0] ^ MASK;
      end else begin
         bus.IMEM_RVALID = 1'b0;
         bus.IMEM_RDATA  = 32'h0;
      end
      bus2.IMEM_RVALID = g2;
      bus2.IMEM_RDATA  = a2 ^ MASK;
   end

   // ---------------- scoreboard ----------------
   int n_checks;
   int n_fail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input int l);
      rst_n = 1'b0;
      stall = 1'b0;
      br    = 1'b0;
      tgt   = 32'h0;
      bus.IMEM_GNT  = 1'b1;
      bus2.IMEM_GNT = 1'b1;
      lat   = l;
      repeat (3) tick();
   endtask

   task automatic check_fr(input string tag, input logic [31:0] pc, input logic [31:0] pc4);
      check({tag, ".valid"}, 32'(fr_valid), 32'd1);
      check({tag, ".pc"},    fr_pc,   pc);
      check({tag, ".pc4"},   fr_pc_4, pc4);
      check({tag, ".mem"},   fr_mem,  pc ^ MASK);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Reset state, 1-cycle memory
      apply_reset(1);
      check("rst.mem",   fr_mem, NOP);
      check("rst.pc",    fr_pc, 32'h0);
      check("rst.pc4",   fr_pc_4, 32'h0);
      check("rst.valid", 32'(fr_valid), 32'd0);
      check("rst.req",   32'(bus.IMEM_REQ), 32'd0);
      check("rst.addr",  bus.IMEM_ADDR, 32'h0);
      check("rst.state", 32'(dbg_state), 32'd0);
      check("rst.addr2", bus2.IMEM_ADDR, 32'hFFFF_FFF8);
      rst_n = 1'b1;

      // E1: first grant, nothing back yet
      tick();
      check("e1.valid", 32'(fr_valid), 32'd0);
      check("e1.addr",  bus.IMEM_ADDR, 32'h4);
      // E2: first instruction via bypass
      tick();
      check_fr("e2", 32'h0, 32'h4);
      check("wrap0.pc",  fr_pc2, 32'hFFFF_FFF8);
      check("wrap0.pc4", fr_pc_42, 32'hFFFF_FFFC);
      tick();
      check_fr("e3", 32'h4, 32'h8);
      check("wrap1.pc",  fr_pc2, 32'hFFFF_FFFC);
      check("wrap1.pc4", fr_pc_42, 32'h0);
      tick();
      check_fr("e4", 32'h8, 32'hC);
      check("wrap2.pc",  fr_pc2, 32'h0);
      check("wrap2.mem", fr_mem2, MASK);
      tick();
      check_fr("e5", 32'hC, 32'h10);

      // Stall for 3 cycles: IF/ID frozen, credits run out
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_fr($sformatf("stall%0d", i), 32'hC, 32'h10);
         check($sformatf("stall%0d.req", i), 32'(bus.IMEM_REQ), 32'd0);
      end
      stall = 1'b0;
      tick();
      check_fr("rel0", 32'h10, 32'h14);
      tick();
      check_fr("rel1", 32'h14, 32'h18);
      tick();
      check_fr("rel2", 32'h18, 32'h1C);

      // Grant withheld for 5 cycles
      bus.IMEM_GNT = 1'b0;
      tick();
      check_fr("ng0", 32'h1C, 32'h20);
      check("ng0.req",  32'(bus.IMEM_REQ), 32'd1);
      check("ng0.addr", bus.IMEM_ADDR, 32'h20);
      for (int i = 1; i < 5; i++) begin
         tick();
         check($sformatf("ng%0d.valid", i), 32'(fr_valid), 32'd0);
         check($sformatf("ng%0d.mem", i),   fr_mem, NOP);
         check($sformatf("ng%0d.pc", i),    fr_pc, 32'h1C);
         check($sformatf("ng%0d.req", i),   32'(bus.IMEM_REQ), 32'd1);
         check($sformatf("ng%0d.addr", i),  bus.IMEM_ADDR, 32'h20);
      end
      bus.IMEM_GNT = 1'b1;
      tick();
      check("ng5.valid", 32'(fr_valid), 32'd0);
      tick();
      check_fr("ng6", 32'h20, 32'h24);

      // 3-cycle memory, redirect with two requests outstanding
      apply_reset(3);
      rst_n = 1'b1;
      tick();
      tick();
      check("br.pre.req", 32'(bus.IMEM_REQ), 32'd0);
      br  = 1'b1;
      tgt = 32'h0000_0103;
      check("br.cyc.req", 32'(bus.IMEM_REQ), 32'd0);
      tick();
      br  = 1'b0;
      tgt = 32'h0;
      check("br0.valid", 32'(fr_valid), 32'd0);
      check("br0.addr",  bus.IMEM_ADDR, 32'h100);
      check("br0.state", 32'(dbg_state), 32'd1);
      check("br0.req",   32'(bus.IMEM_REQ), 32'd0);
      tick();
      check("br1.valid", 32'(fr_valid), 32'd0);
      check("br1.req",   32'(bus.IMEM_REQ), 32'd0);
      check("br1.state", 32'(dbg_state), 32'd1);
      tick();
      check("br2.valid", 32'(fr_valid), 32'd0);
      check("br2.state", 32'(dbg_state), 32'd0);
      check("br2.req",   32'(bus.IMEM_REQ), 32'd1);
      check("br2.addr",  bus.IMEM_ADDR, 32'h100);
      for (int i = 3; i < 6; i++) begin
         tick();
         check($sformatf("br%0d.valid", i), 32'(fr_valid), 32'd0);
      end
      tick();
      check_fr("br6", 32'h100, 32'h104);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
